// File: rtl/adc_scan_ctrl.sv
// Scan sequencer for an 8-channel 12-bit serial ADC: conversion start, SCLK, config word out,
// result in, and a valid/ready result stream tagged with the channel each result belongs to.
module adc_scan_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);

  // Lowest enabled channel strictly above cur, wrapping; a lone channel maps to itself.
  function automatic logic [2:0] next_ch_f(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] cand;
    logic       found;
    next_ch_f = cur;
    found     = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = cur + 3'(i);
      if (!found && mask[cand]) begin
        next_ch_f = cand;
        found     = 1'b1;
      end
    end
  endfunction

  // Single-ended, unipolar, awake: {S/D, O/S, S1, S0, UNI, SLP}.
  function automatic logic [5:0] cfg_word_f(input logic [2:0] ch);
    cfg_word_f = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [15:0] div_r;
  logic [3:0]  bit_r;
  logic [5:0]  cfg_r;
  logic [11:0] shift_r;
  logic [2:0]  cur_ch_r;
  logic [2:0]  prev_ch_r;
  logic        primed_r;
  logic        start_s;
  logic [2:0]  next_ch_s;

  // A new frame starts from IDLE, or at the last GAP cycle, while scanning is requested.
  always_comb begin
    start_s   = 1'b0;
    next_ch_s = next_ch_f(ch_mask, cur_ch_r);
    if (enable && (ch_mask != 8'd0)) begin
      case (state_r)
        IDLE:    start_s = 1'b1;
        GAP:     start_s = (cnt_r == GAP_LAST);
        default: start_s = 1'b0;
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  // Frame sequencer, serial interface and result stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 16'd0;
      div_r        <= 16'd0;
      bit_r        <= 4'd0;
      cfg_r        <= 6'd0;
      shift_r      <= 12'd0;
      cur_ch_r     <= 3'd7;
      prev_ch_r    <= 3'd0;
      primed_r     <= 1'b0;
      adc_cs_n     <= 1'b0;
      adc_sclk     <= 1'b0;
      adc_din      <= 1'b0;
      sample_data  <= 12'd0;
      sample_ch    <= 3'd0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (start_s) begin
        state_r   <= CONV;
        busy      <= 1'b1;
        adc_cs_n  <= 1'b1;
        adc_din   <= 1'b0;
        cnt_r     <= 16'd0;
        prev_ch_r <= cur_ch_r;
        cur_ch_r  <= next_ch_s;
        cfg_r     <= cfg_word_f(next_ch_s);
      end else begin
        case (state_r)
          IDLE: begin
            adc_cs_n <= 1'b0;
            busy     <= 1'b0;
          end
          CONV: begin
            if (cnt_r == CONV_LAST) begin
              state_r  <= SHIFT;
              adc_cs_n <= 1'b0;
              adc_sclk <= 1'b0;
              adc_din  <= cfg_r[5];
              cfg_r    <= {cfg_r[4:0], 1'b0};
              div_r    <= 16'd0;
              bit_r    <= 4'd0;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
          SHIFT: begin
            if (div_r != DIV_LAST) begin
              div_r <= div_r + 16'd1;
            end else begin
              div_r <= 16'd0;
              if (!adc_sclk) begin
                adc_sclk <= 1'b1;
                shift_r  <= {shift_r[10:0], adc_dout};
              end else begin
                adc_sclk <= 1'b0;
                if (bit_r == 4'd11) begin
                  state_r <= GAP;
                  cnt_r   <= 16'd0;
                  adc_din <= 1'b0;
                  // The word just shifted in answers the previous frame's config.
                  if (primed_r) begin
                    sample_data  <= shift_r;
                    sample_ch    <= prev_ch_r;
                    sample_valid <= 1'b1;
                    overrun      <= sample_valid && !sample_ready;
                  end else begin
                    primed_r <= 1'b1;
                  end
                end else begin
                  bit_r   <= bit_r + 4'd1;
                  adc_din <= cfg_r[5];
                  cfg_r   <= {cfg_r[4:0], 1'b0};
                end
              end
            end
          end
          GAP: begin
            if (cnt_r == GAP_LAST) begin
              state_r  <= IDLE;
              busy     <= 1'b0;
              primed_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
          default: begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            adc_din  <= 1'b0;
            primed_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: an LTC2308-like ADC model, a stream monitor and directed runs
// with randomized masks and conversion values, scored against a round-robin reference.
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'd0;
  logic        adc_dout = 1'b0;
  logic        sample_ready = 1'b0;
  logic        adc_cs_n, adc_sclk, adc_din, sample_valid, overrun, busy;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;

  adc_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc++;

  // ADC model: config captured on SCLK rise, result MSB after CONVST falls, next bits on SCLK fall.
  logic [11:0] ch_val [8];
  logic [11:0] conv_word = 12'd0;
  logic [5:0]  cap = 6'd0;
  int          cap_n = 0;
  int          bit_n = 0;
  logic [2:0]  last_cfg_ch = 3'd0;
  logic        cs_prev = 1'b0;
  logic        sclk_prev = 1'b0;
  logic [5:0]  cfgraw_q [$];
  logic [2:0]  cfgch_q [$];

  always @(posedge clk) begin
    #1;
    if (!cs_prev && adc_cs_n) conv_word = ch_val[last_cfg_ch];
    if (cs_prev && !adc_cs_n) begin
      cap_n    = 0;
      bit_n    = 0;
      adc_dout = conv_word[11];
    end
    if (!sclk_prev && adc_sclk) begin
      bit_n++;
      if (cap_n < 6) begin
        cap = {cap[4:0], adc_din};
        cap_n++;
        if (cap_n == 6) begin
          last_cfg_ch = {cap[3], cap[2], cap[4]};
          cfgraw_q.push_back(cap);
          cfgch_q.push_back({cap[3], cap[2], cap[4]});
        end
      end
    end
    if (sclk_prev && !adc_sclk) adc_dout = (bit_n < 12) ? conv_word[11 - bit_n] : 1'b0;
    cs_prev   = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  // Stream monitor: accepted transfers, overrun pulses and valid drops.
  logic [2:0]  pub_ch_q [$];
  logic [11:0] pub_data_q [$];
  int          ovr_cnt = 0;
  int          vfall = 0;
  logic        v_prev = 1'b0;

  always @(posedge clk) begin
    if (sample_valid && sample_ready) begin
      pub_ch_q.push_back(sample_ch);
      pub_data_q.push_back(sample_data);
    end
    if (overrun === 1'b1) ovr_cnt++;
    if (v_prev && !sample_valid) vfall++;
    v_prev = sample_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cs(input logic lvl, output int unsigned t);
    int n = 0;
    while (adc_cs_n !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("cs_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic wait_idle(output int unsigned t);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic wait_pubs(input int want);
    int n = 0;
    while (pub_ch_q.size() < want && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("pub_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cfgs(input int want);
    int n = 0;
    while (cfgch_q.size() < want && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("cfg_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_queues();
    cfgraw_q.delete();
    cfgch_q.delete();
    pub_ch_q.delete();
    pub_data_q.delete();
  endtask

  task automatic rand_vals();
    for (int i = 0; i < 8; i++) ch_val[i] = 12'($urandom);
  endtask

  // Reference scan order: enabled channels ascending, first one above c, else the lowest.
  function automatic logic [2:0] rr_next(input logic [7:0] m, input logic [2:0] c);
    int lst [$];
    for (int i = 0; i < 8; i++) if (m[i]) lst.push_back(i);
    foreach (lst[k]) if (lst[k] > int'(c)) return 3'(lst[k]);
    return 3'(lst[0]);
  endfunction

  function automatic logic [5:0] cfg_of(input logic [2:0] c);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_cs_n"}, adc_cs_n, 1'b0);
    chk({tag, "_sclk"}, adc_sclk, 1'b0);
    chk({tag, "_din"}, adc_din, 1'b0);
    chk({tag, "_data"}, sample_data, 12'd0);
    chk({tag, "_ch"}, sample_ch, 3'd0);
    chk({tag, "_valid"}, sample_valid, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Whole-run scoring with ready held high: each frame's config follows the scan order,
  // every frame but the priming one publishes the previous frame's channel and its value.
  task automatic check_run(input string tag, input logic [7:0] m, input logic [2:0] after);
    logic [2:0] e;
    e = after;
    chk({tag, "_ncfg"}, 32'(cfgch_q.size() >= 2), 32'd1);
    chk({tag, "_npub"}, pub_ch_q.size(), cfgch_q.size() - 1);
    for (int i = 0; i < cfgch_q.size(); i++) begin
      e = rr_next(m, e);
      chk({tag, "_cfgch"}, cfgch_q[i], e);
      chk({tag, "_cfgraw"}, cfgraw_q[i], cfg_of(e));
    end
    for (int i = 0; i < pub_ch_q.size() && i < cfgch_q.size(); i++) begin
      chk({tag, "_pubch"}, pub_ch_q[i], cfgch_q[i]);
      chk({tag, "_pubdata"}, pub_data_q[i], ch_val[pub_ch_q[i]]);
    end
  endtask

  initial begin
    int unsigned t_r1, t_f1, t_r2, t_r3, t_idle, t_x;
    logic [7:0]  m;
    logic [2:0]  last_ch;

    // Reset state
    rand_vals();
    tick(3);
    chk_reset("rst");
    rst_n = 1'b1;
    tick(3);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cs_n", adc_cs_n, 1'b0);

    // Single channel 0, fixed value, frame timing and priming
    ch_val[0]    = 12'hA5C;
    ch_mask      = 8'h01;
    sample_ready = 1'b1;
    clear_queues();
    enable = 1'b1;
    wait_cs(1'b1, t_r1);
    wait_cs(1'b0, t_f1);
    chk("conv_len", t_f1 - t_r1, 32'd80);
    wait_cs(1'b1, t_r2);
    chk("frame_period", t_r2 - t_r1, 32'd130);
    chk("prime_no_pub", pub_ch_q.size(), 32'd0);
    wait_cs(1'b0, t_x);
    wait_cs(1'b1, t_r3);
    chk("frame_period2", t_r3 - t_r2, 32'd130);
    chk("first_pub_n", pub_ch_q.size(), 32'd1);
    if (pub_ch_q.size() >= 1) begin
      chk("first_pub_ch", pub_ch_q[0], 3'd0);
      chk("first_pub_data", pub_data_q[0], 12'hA5C);
    end
    chk("din_seq0", cfgraw_q[0], 6'b100010);
    chk("din_seq1", cfgraw_q[1], 6'b100010);
    // Drop enable during CONV: the frame runs to completion, then IDLE
    tick(10);
    enable = 1'b0;
    wait_idle(t_idle);
    chk("drain_len", t_idle - t_r3, 32'd130);
    chk("drain_busy", busy, 1'b0);
    chk("drain_cs_n", adc_cs_n, 1'b0);
    chk("drain_sclk", adc_sclk, 1'b0);
    check_run("ch0", 8'h01, 3'd7);
    last_ch = cfgch_q[$];

    // Mask 1010_0100 from channel 0: configs 2,5,7,2 and publishes 2,5,7
    rand_vals();
    ch_mask = 8'b1010_0100;
    clear_queues();
    enable = 1'b1;
    wait_cs(1'b1, t_r1);
    wait_cs(1'b0, t_x);
    wait_cs(1'b1, t_r2);
    chk("reprime_no_pub", pub_ch_q.size(), 32'd0);
    wait_pubs(3);
    enable = 1'b0;
    wait_idle(t_idle);
    chk("mA4_ncfg4", 32'(cfgch_q.size() >= 4), 32'd1);
    check_run("mA4", 8'b1010_0100, last_ch);
    last_ch = cfgch_q[$];

    // Randomized masks and values
    for (int r = 0; r < 3; r++) begin
      m = 8'($urandom_range(1, 255));
      rand_vals();
      ch_mask = m;
      clear_queues();
      enable = 1'b1;
      wait_pubs(int'($urandom_range(2, 5)));
      enable = 1'b0;
      wait_idle(t_idle);
      check_run("rand", m, last_ch);
      last_ch = cfgch_q[$];
    end

    // Mask change mid-SHIFT: current frame keeps ch0, following frames move to ch7
    rand_vals();
    ch_mask = 8'h01;
    clear_queues();
    enable = 1'b1;
    wait_cs(1'b1, t_x);
    wait_cs(1'b0, t_x);
    wait_cs(1'b1, t_x);
    wait_cs(1'b0, t_x);
    tick(7);
    ch_mask = 8'h80;
    wait_pubs(3);
    enable = 1'b0;
    wait_idle(t_idle);
    chk("mchg_cfg0", cfgch_q[0], 3'd0);
    chk("mchg_cfg1", cfgch_q[1], 3'd0);
    chk("mchg_cfg2", cfgch_q[2], 3'd7);
    chk("mchg_pub0", pub_ch_q[0], 3'd0);
    chk("mchg_pub1", pub_ch_q[1], 3'd0);
    chk("mchg_pub2", pub_ch_q[2], 3'd7);
    chk("mchg_data1", pub_data_q[1], ch_val[0]);
    chk("mchg_data2", pub_data_q[2], ch_val[7]);
    last_ch = cfgch_q[$];

    // Consumer stalls for three publishes: two overruns, latest result held
    rand_vals();
    ch_val[2]    = ch_val[1] ^ 12'hFFF;
    ch_mask      = 8'b0000_0110;
    sample_ready = 1'b0;
    clear_queues();
    ovr_cnt = 0;
    vfall   = 0;
    enable  = 1'b1;
    wait_cfgs(4);
    enable = 1'b0;
    wait_idle(t_idle);
    chk("stall_overruns", ovr_cnt, 32'd2);
    chk("stall_no_drop", vfall, 32'd0);
    chk("stall_valid", sample_valid, 1'b1);
    chk("stall_ch", sample_ch, cfgch_q[2]);
    chk("stall_data", sample_data, ch_val[cfgch_q[2]]);
    chk("stall_no_accept", pub_ch_q.size(), 32'd0);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    chk("ready_drops_valid", sample_valid, 1'b0);
    chk("ready_accept_n", pub_ch_q.size(), 32'd1);
    chk("ready_accept_ch", pub_ch_q[0], cfgch_q[2]);

    // Reset for one cycle mid-SHIFT, enable kept high
    m = 8'($urandom_range(1, 255));
    rand_vals();
    ch_mask      = m;
    sample_ready = 1'b1;
    enable       = 1'b1;
    wait_cs(1'b1, t_x);
    wait_cs(1'b0, t_x);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    chk_reset("midrst");
    rst_n = 1'b1;
    clear_queues();
    wait_pubs(2);
    enable = 1'b0;
    wait_idle(t_idle);
    check_run("after_rst", m, 3'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
